// File: rtl/heartbeat_sched.sv
// Round-robin scheduler that serialises one requester payload per frame onto a Manchester-coded line.
// Build option: define HEARTBEAT_SCHED_PARITY_EN to append an even-parity bit over id and payload.
module heartbeat_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    signal
);

  localparam int unsigned IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
`ifdef HEARTBEAT_SCHED_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FL   = 1 + IDW + WIDTH + PB;
  localparam int unsigned LAST = 2 * FL - 1;
  localparam int unsigned CW   = 8;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   sel_q, sel_d;
  logic [FL-1:0]    sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  grant_d;
  logic             busy_d, frame_done_d, signal_d;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] payload;
  logic [FL-1:0]    frame;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      signal     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      grant      <= grant_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      signal     <= signal_d;
    end
  end

  // Round-robin search: first request at or above ptr, wrapping
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    payload = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_q == IDW'(i)) payload = data[i*WIDTH +: WIDTH];
    end
  end

`ifdef HEARTBEAT_SCHED_PARITY_EN
  assign frame = {1'b1, sel_q, payload, ^{sel_q, payload}};
`else
  assign frame = {1'b1, sel_q, payload};
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB:  state_d = (|grant) ? S_SEND : S_IDLE;
      S_SEND: if (cnt_q == CW'(LAST)) state_d = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (cnt_q == CW'(GAP - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of outputs and datapath; grant is resolved on the edge into ARB so it is a clean flop
  always_comb begin
    grant_d      = '0;
    frame_done_d = 1'b0;
    signal_d     = 1'b0;
    busy_d       = (state_d != S_IDLE);
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d[pick_idx] = 1'b1;
          sel_d             = pick_idx;
        end
      end
      S_ARB: begin
        if (|grant) begin
          sh_d     = frame;
          cnt_d    = '0;
          signal_d = 1'b1;
          ptr_d    = (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      S_SEND: begin
        frame_done_d = (cnt_q == CW'(LAST - 1));
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CW'(LAST)) begin
          cnt_d = '0;
          sh_d  = '0;
        end else if (!cnt_q[0]) begin
          signal_d = ~sh_q[FL-1];
        end else begin
          signal_d = sh_q[FL-2];
          sh_d     = sh_q << 1;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP - 1)) cnt_d = '0;
        else                       cnt_d = cnt_q + 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_heartbeat_sched.sv
// Self-checking bench for heartbeat_sched: table of hand-derived grants, random frames against
// a frame-level reference model, and a mid-frame reset sequence.
module tb_heartbeat_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int GAP   = 4;
  localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1;
`ifdef HEARTBEAT_SCHED_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL       = 1 + IDW + WIDTH + PB;
  localparam int SEND_LEN = 2 * FL;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  frame_done;
  logic                  signal;

  heartbeat_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data),
    .grant(grant), .busy(busy), .frame_done(frame_done), .signal(signal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ptr_m = 0;
  int last_grant_cyc = -1;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first requester at or above the pointer, wrapping
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
    end
    return -1;
  endfunction

  // Expected line waveform, element c = signal in SEND cycle c
  function automatic logic [63:0] exp_wave(input int k, input logic [WIDTH-1:0] pl);
    logic [63:0] w;
    int bits[$];
    int ones;
    w = '0;
    ones = 0;
    bits.push_back(1);
    for (int i = IDW - 1; i >= 0; i--) begin
      bits.push_back((k >> i) & 1);
      ones += (k >> i) & 1;
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      bits.push_back(int'(pl[i]));
      ones += int'(pl[i]);
    end
    if (PB == 1) bits.push_back(ones % 2);
    for (int i = 0; i < bits.size(); i++) begin
      w[2*i]   = (bits[i] != 0);
      w[2*i+1] = (bits[i] == 0);
    end
    return w;
  endfunction

  // One complete frame: arbitration, SEND, GAP and the trailing IDLE cycle
  task automatic do_frame(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d,
                          input logic [NREQ-1:0] tab_g, input bit drop, input bit scramble,
                          input bit chk_space);
    logic [NREQ-1:0] exp_g;
    logic [WIDTH-1:0] pl;
    logic [63:0] act_w, act_fd;
    int k, gq, bq, gz, fd_wait;
    bit got;
    req = r;
    data = d;
    exp_g = '0;
    if (tab_g != '0) exp_g = tab_g;
    else exp_g[model_pick(r)] = 1'b1;
    k = 0;
    for (int i = 0; i < NREQ; i++) if (exp_g[i]) k = i;
    got = 0;
    fd_wait = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_done) fd_wait++;
      if (grant != '0) begin
        got = 1;
        break;
      end
    end
    check("grant_seen", 64'(got), 64'(1));
    if (!got) return;
    check("no_fd_before_grant", 64'(fd_wait), 64'(0));
    check("grant", 64'(grant), 64'(exp_g));
    check("busy_arb", 64'(busy), 64'(1));
    if (chk_space) check("spacing", 64'(cyc - last_grant_cyc), 64'(2 + SEND_LEN + GAP));
    last_grant_cyc = cyc;
    pl = d[k*WIDTH +: WIDTH];
    ptr_m = (k + 1) % NREQ;
    act_w = '0;
    act_fd = '0;
    gq = 0;
    bq = 0;
    gz = 0;
    for (int c = 0; c < SEND_LEN; c++) begin
      @(negedge clk);
      act_w[c] = signal;
      act_fd[c] = frame_done;
      if (grant != '0) gq++;
      if (!busy) bq++;
      if (c == 0) begin
        data = {$urandom, $urandom};
        if (drop) req = req & ~exp_g;
        if (scramble) req = NREQ'($urandom);
      end
    end
    check("wave", act_w, exp_wave(k, pl));
    check("frame_done", act_fd, 64'(1) << (SEND_LEN - 1));
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      if (signal || frame_done) gz++;
      if (grant != '0) gq++;
      if (!busy) bq++;
    end
    check("gap_quiet", 64'(gz), 64'(0));
    check("grant_quiet", 64'(gq), 64'(0));
    check("busy_high", 64'(bq), 64'(0));
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_signal", 64'(signal), 64'(0));
  endtask

  typedef struct {
    logic [NREQ-1:0]       r;
    logic [NREQ*WIDTH-1:0] d;
    bit                    drop;
    logic [NREQ-1:0]       exp_g;
  } vec_t;

  vec_t tab[$];

  initial begin
    int bad;
    // Hand-derived grant order, pointer starting at 0 after reset
    tab.push_back('{4'b1111, 32'h44332211, 1'b0, 4'b0001});
    tab.push_back('{4'b1111, 32'h44332211, 1'b0, 4'b0010});
    tab.push_back('{4'b1111, 32'h44332211, 1'b0, 4'b0100});
    tab.push_back('{4'b1111, 32'h44332211, 1'b0, 4'b1000});
    tab.push_back('{4'b1111, 32'hDEADBEEF, 1'b1, 4'b0001});
    tab.push_back('{4'b0010, 32'h0000A500, 1'b1, 4'b0010});
    tab.push_back('{4'b0100, 32'h00FF0000, 1'b1, 4'b0100});
    tab.push_back('{4'b0011, 32'h00005A3C, 1'b1, 4'b0001});
    tab.push_back('{4'b0010, 32'h00005A3C, 1'b1, 4'b0010});
    tab.push_back('{4'b1001, 32'h80000001, 1'b0, 4'b1000});
    tab.push_back('{4'b1001, 32'h80000001, 1'b1, 4'b0001});

    rst_n = 1'b0;
    req = '0;
    data = '0;
    #1;
    check("reset_grant", 64'(grant), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_fd", 64'(frame_done), 64'(0));
    check("reset_signal", 64'(signal), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;

    foreach (tab[i]) do_frame(tab[i].r, tab[i].d, tab[i].exp_g, tab[i].drop, 1'b0, i != 0);

    // Random frames against the round-robin model, with req/data churn mid-frame
    for (int n = 0; n < 12; n++) begin
      do_frame(NREQ'($urandom_range(1, 15)), {$urandom, $urandom}, '0,
               bit'($urandom_range(0, 1)), 1'b1, 1'b1);
    end

    // Reset in the middle of a frame
    req = 4'b0100;
    data = 32'h12345678;
    bad = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        bad = 0;
        break;
      end
    end
    check("mid_grant", 64'(grant), 64'(4'b0100));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_signal", 64'(signal), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_timeout", 64'(bad), 64'(0));
    req = 4'b1001;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (frame_done || signal || busy || grant != '0) bad++;
    end
    check("rst_hold_quiet", 64'(bad), 64'(0));
    rst_n = 1'b1;
    ptr_m = 0;
    do_frame(4'b1001, 32'hC3000081, 4'b0001, 1'b1, 1'b0, 1'b0);
    do_frame(4'b1000, 32'hC3000081, 4'b1000, 1'b1, 1'b0, 1'b1);

    // No requests: scheduler stays idle
    req = '0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || grant != '0 || signal) bad++;
    end
    check("idle_no_req", 64'(bad), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
